// File: rtl/mix_core_n.sv
// Multi-source SDRAM audio mixer: reads NUM_SRC stereo tracks, applies a per-source
// gain, sums with saturation and stores the mix to SDRAM and/or streams it out.
module mix_core_n #(
  parameter int NUM_SRC = 4,
  parameter int ADDR_W  = 23,
  parameter int GAIN_W  = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            mix_start,
  input  logic                            mix_abort,
  input  logic [(NUM_SRC+1)*ADDR_W-1:0]   mix_select,
  input  logic [ADDR_W-1:0]               mix_length,
  input  logic [NUM_SRC-1:0]              mix_enable,
  input  logic [NUM_SRC*GAIN_W-1:0]       mix_gain,
  input  logic [1:0]                      mix_mode,
  output logic                            mix_busy,
  output logic                            mix_done,
  output logic                            mix_read,
  output logic                            mix_write,
  output logic [ADDR_W-1:0]               mix_addr,
  output logic [31:0]                     mix_writedata,
  input  logic [31:0]                     mix_readdata,
  input  logic                            mix_sdram_finished,
  output logic                            play_audio_valid,
  output logic [31:0]                     play_audio_data,
  input  logic                            play_audio_ready
);

  localparam int SRC_W  = $clog2(NUM_SRC + 1);
  localparam int PROD_W = 16 + GAIN_W + 1;
  localparam int ACC_W  = 16 + GAIN_W + $clog2(NUM_SRC) + 1;
  localparam int SHIFT  = GAIN_W - 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_READ, S_SAT, S_WRITE, S_PLAY, S_NEXT, S_DONE
  } state_t;

  state_t                          state_q;
  logic [(NUM_SRC+1)*ADDR_W-1:0]   sel_q;
  logic [ADDR_W-1:0]               len_q;
  logic [NUM_SRC-1:0]              en_q;
  logic [NUM_SRC*GAIN_W-1:0]       gain_q;
  logic [1:0]                      mode_q;
  logic [ADDR_W-1:0]               i_q;
  logic [SRC_W-1:0]                k_q;
  logic signed [ACC_W-1:0]         acc_l_q, acc_r_q;
  logic                            abort_q;
  logic                            busy_q, done_q, read_q, write_q, valid_q;
  logic [ADDR_W-1:0]               addr_q;
  logic [31:0]                     wdata_q, pdata_q;

  logic [SRC_W-1:0]                nxt_k;
  logic                            nxt_found;
  logic [GAIN_W-1:0]               gain_cur;
  logic signed [PROD_W-1:0]        samp_l, samp_r, gain_s, prod_l, prod_r;
  logic signed [ACC_W-1:0]         term_l, term_r;
  logic [31:0]                     mix_word;
  logic                            abort_now;
  logic [ADDR_W-1:0]               first_addr, cur_addr, dst_addr;

  function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX) return 16'h7fff;
    if (a < SAT_MIN) return 16'h8000;
    return a[15:0];
  endfunction

  function automatic logic [ADDR_W-1:0] base_of(input logic [(NUM_SRC+1)*ADDR_W-1:0] sel,
                                                input logic [SRC_W-1:0] k);
    logic [ADDR_W-1:0] b;
    b = '0;
    for (int j = 0; j <= NUM_SRC; j++)
      if (int'(k) == j) b = sel[j*ADDR_W +: ADDR_W];
    return b;
  endfunction

  // Lowest enabled source above the current one; k_q == 0 means "none visited yet".
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    nxt_k     = '0;
    nxt_found = 1'b0;
    for (int j = NUM_SRC; j >= 1; j--) begin
      if (en_q[j-1] && j > int'(k_q)) begin
        nxt_k     = SRC_W'(j);
        nxt_found = 1'b1;
      end
    end
  end

  always_comb begin
    gain_cur = '0;
    for (int j = 1; j <= NUM_SRC; j++)
      if (int'(k_q) == j) gain_cur = gain_q[(j-1)*GAIN_W +: GAIN_W];
  end

  assign samp_l   = PROD_W'($signed(mix_readdata[31:16]));
  assign samp_r   = PROD_W'($signed(mix_readdata[15:0]));
  assign gain_s   = PROD_W'({1'b0, gain_cur});
  assign prod_l   = samp_l * gain_s;
  assign prod_r   = samp_r * gain_s;
  assign term_l   = ACC_W'(prod_l >>> SHIFT);
  assign term_r   = ACC_W'(prod_r >>> SHIFT);
  assign mix_word = {sat16(acc_l_q), sat16(acc_r_q)};

  assign abort_now  = abort_q | mix_abort;
  assign first_addr = base_of(sel_q, nxt_k) + i_q;
  assign cur_addr   = base_of(sel_q, k_q) + i_q;
  assign dst_addr   = sel_q[ADDR_W-1:0] + i_q;

  // NOTE: sequential state uses non-blocking assignments only; the latched job
  // configuration is reset too so an idle core exposes no stale addresses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      len_q   <= '0;
      en_q    <= '0;
      gain_q  <= '0;
      mode_q  <= '0;
      i_q     <= '0;
      k_q     <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (mix_start) begin
            sel_q   <= mix_select;
            len_q   <= mix_length;
            en_q    <= mix_enable;
            gain_q  <= mix_gain;
            mode_q  <= (mix_mode == 2'b00) ? 2'b01 : mix_mode;
            i_q     <= '0;
            k_q     <= '0;
            abort_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_CLR;
          end
        end
        S_CLR: begin
          if (abort_now) begin
            busy_q <= 1'b0; abort_q <= 1'b0; state_q <= S_IDLE;
          end else if (len_q == '0) begin
            busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_DONE;
          end else begin
            acc_l_q <= '0;
            acc_r_q <= '0;
            k_q     <= nxt_k;
            if (nxt_found) begin
              read_q  <= 1'b1;
              addr_q  <= first_addr;
              state_q <= S_READ;
            end else begin
              state_q <= S_SAT;
            end
          end
        end
        S_READ: begin
          if (!read_q) begin
            // Gap cycle between two reads: no request is in flight here.
            if (abort_now) begin
              busy_q <= 1'b0; abort_q <= 1'b0; state_q <= S_IDLE;
            end else begin
              read_q <= 1'b1;
              addr_q <= cur_addr;
            end
          end else if (mix_sdram_finished) begin
            read_q  <= 1'b0;
            acc_l_q <= acc_l_q + term_l;
            acc_r_q <= acc_r_q + term_r;
            if (abort_now) begin
              busy_q <= 1'b0; abort_q <= 1'b0; state_q <= S_IDLE;
            end else if (nxt_found) begin
              k_q <= nxt_k;
            end else begin
              state_q <= S_SAT;
            end
          end else begin
            abort_q <= abort_now;
          end
        end
        S_SAT: begin
          wdata_q <= mix_word;
          pdata_q <= mix_word;
          if (abort_now) begin
            busy_q <= 1'b0; abort_q <= 1'b0; state_q <= S_IDLE;
          end else if (mode_q[0]) begin
            write_q <= 1'b1;
            addr_q  <= dst_addr;
            state_q <= S_WRITE;
          end else begin
            valid_q <= 1'b1;
            state_q <= S_PLAY;
          end
        end
        S_WRITE: begin
          if (mix_sdram_finished) begin
            write_q <= 1'b0;
            if (abort_now) begin
              busy_q <= 1'b0; abort_q <= 1'b0; state_q <= S_IDLE;
            end else if (mode_q[1]) begin
              valid_q <= 1'b1;
              state_q <= S_PLAY;
            end else begin
              state_q <= S_NEXT;
            end
          end else begin
            abort_q <= abort_now;
          end
        end
        S_PLAY: begin
          if (play_audio_ready) begin
            valid_q <= 1'b0;
            if (abort_now) begin
              busy_q <= 1'b0; abort_q <= 1'b0; state_q <= S_IDLE;
            end else begin
              state_q <= S_NEXT;
            end
          end else begin
            abort_q <= abort_now;
          end
        end
        S_NEXT: begin
          if (abort_now) begin
            busy_q <= 1'b0; abort_q <= 1'b0; state_q <= S_IDLE;
          end else begin
            k_q <= '0;
            i_q <= i_q + 1'b1;
            if ((i_q + 1'b1) == len_q) begin
              busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_DONE;
            end else begin
              state_q <= S_CLR;
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mix_busy         = busy_q;
  assign mix_done         = done_q;
  assign mix_read         = read_q;
  assign mix_write        = write_q;
  assign mix_addr         = addr_q;
  assign mix_writedata    = wdata_q;
  assign play_audio_valid = valid_q;
  assign play_audio_data  = pdata_q;

endmodule

// File: tb/tb_mix_core_n.sv
// Self-checking bench for mix_core_n: randomized SDRAM/audio responders and a
// word-level reference model of the expected read/write/play traffic.
module tb_mix_core_n;
  localparam int NUM_SRC = 4;
  localparam int ADDR_W  = 23;
  localparam int GAIN_W  = 8;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic mix_start = 1'b0, mix_abort = 1'b0;
  logic [(NUM_SRC+1)*ADDR_W-1:0] mix_select = '0;
  logic [ADDR_W-1:0] mix_length = '0;
  logic [NUM_SRC-1:0] mix_enable = '0;
  logic [NUM_SRC*GAIN_W-1:0] mix_gain = '0;
  logic [1:0] mix_mode = '0;
  logic mix_busy, mix_done, mix_read, mix_write, play_audio_valid;
  logic [ADDR_W-1:0] mix_addr;
  logic [31:0] mix_writedata, play_audio_data;
  logic [31:0] mix_readdata = '0;
  logic mix_sdram_finished = 1'b0;
  logic play_audio_ready = 1'b0;

  mix_core_n #(.NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .GAIN_W(GAIN_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .mix_start(mix_start), .mix_abort(mix_abort),
    .mix_select(mix_select), .mix_length(mix_length), .mix_enable(mix_enable),
    .mix_gain(mix_gain), .mix_mode(mix_mode), .mix_busy(mix_busy), .mix_done(mix_done),
    .mix_read(mix_read), .mix_write(mix_write), .mix_addr(mix_addr),
    .mix_writedata(mix_writedata), .mix_readdata(mix_readdata),
    .mix_sdram_finished(mix_sdram_finished), .play_audio_valid(play_audio_valid),
    .play_audio_data(play_audio_data), .play_audio_ready(play_audio_ready)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]        kind;  // 0 read, 1 write, 2 play
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } ev_t;

  ev_t act_q[$];
  ev_t exp_q[$];
  logic [31:0] mem [logic [ADDR_W-1:0]];

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Job configuration
  logic [ADDR_W-1:0] c_sel [0:NUM_SRC];
  logic [GAIN_W-1:0] c_gain [1:NUM_SRC];
  logic [NUM_SRC-1:0] c_en;
  int c_len;
  logic [1:0] c_mode;
  int c_stall;
  bit c_start_abort;

  // Responder / monitor state
  bit hold_fin = 0, real_fin = 0, req_active = 0, held_valid = 0, busy_at_done = 0;
  int lat_left = 0, viol = 0, stall_cfg = 0, stall_left = 0;
  int done_cnt = 0, done_cyc = 0, fin_cyc = 0, s_cyc = 0;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] held_data, last_wdata;

  always @(negedge i_clk) begin
    if (i_rst) begin
      mix_sdram_finished = 0; play_audio_ready = 0; real_fin = 0;
      req_active = 0; held_valid = 0; lat_left = 0;
    end else begin
      if (mix_read && mix_write) viol++;
      if (mix_done) begin done_cnt++; done_cyc = cyc; busy_at_done = mix_busy; end
      mix_readdata = $urandom;
      if (mix_sdram_finished) begin
        if (real_fin && (mix_read || mix_write)) viol++;
        mix_sdram_finished = 0; real_fin = 0; req_active = 0;
      end else if (mix_read || mix_write) begin
        if (req_active && mix_addr !== req_addr) viol++;
        req_active = 1; req_addr = mix_addr;
        if (!hold_fin && lat_left == 0) begin
          mix_sdram_finished = 1; real_fin = 1; fin_cyc = cyc;
          lat_left = $urandom_range(0, 3);
          if (mix_read) begin
            mix_readdata = mem.exists(mix_addr) ? mem[mix_addr] : 32'hdeadbeef;
            act_q.push_back('{kind: 2'd0, addr: mix_addr, data: 32'h0});
          end else begin
            act_q.push_back('{kind: 2'd1, addr: mix_addr, data: mix_writedata});
            last_wdata = mix_writedata;
          end
        end else if (lat_left > 0) lat_left--;
      end else if ($urandom_range(0, 7) == 0) begin
        mix_sdram_finished = 1; real_fin = 0;  // stray strobe, must be ignored
      end
      if (play_audio_valid) begin
        if (held_valid && play_audio_data !== held_data) viol++;
        if (stall_left > 0) begin
          play_audio_ready = 0; stall_left--; held_valid = 1; held_data = play_audio_data;
        end else begin
          play_audio_ready = 1; held_valid = 0;
          act_q.push_back('{kind: 2'd2, addr: '0, data: play_audio_data});
        end
      end else begin
        play_audio_ready = 0; stall_left = stall_cfg; held_valid = 0;
      end
    end
  end

  function automatic logic [15:0] clamp16(input int v);
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  // Reference: expected traffic of a whole job from the word-level rules.
  function automatic void build_exp();
    logic [ADDR_W-1:0] a;
    logic signed [15:0] sl, sr;
    logic [1:0] m;
    int al, ar;
    logic [31:0] w;
    exp_q.delete();
    m = (c_mode == 2'b00) ? 2'b01 : c_mode;
    for (int i = 0; i < c_len; i++) begin
      al = 0; ar = 0;
      for (int k = 1; k <= NUM_SRC; k++) begin
        if (c_en[k-1]) begin
          a = c_sel[k] + ADDR_W'(i);
          if (!mem.exists(a)) mem[a] = $urandom;
          exp_q.push_back('{kind: 2'd0, addr: a, data: 32'h0});
          sl = mem[a][31:16]; sr = mem[a][15:0];
          al += (int'(sl) * int'(c_gain[k])) >>> (GAIN_W - 1);
          ar += (int'(sr) * int'(c_gain[k])) >>> (GAIN_W - 1);
        end
      end
      w = {clamp16(al), clamp16(ar)};
      if (m[0]) exp_q.push_back('{kind: 2'd1, addr: c_sel[0] + ADDR_W'(i), data: w});
      if (m[1]) exp_q.push_back('{kind: 2'd2, addr: '0, data: w});
    end
  endfunction

  task automatic default_cfg();
    for (int k = 0; k <= NUM_SRC; k++) c_sel[k] = ADDR_W'($urandom);
    for (int k = 1; k <= NUM_SRC; k++) c_gain[k] = 8'd128;
    c_en = '1; c_len = 1; c_mode = 2'b01; c_stall = 0; c_start_abort = 0;
  endtask

  task automatic drive_start();
    stall_cfg = c_stall;
    @(negedge i_clk);
    for (int k = 0; k <= NUM_SRC; k++) mix_select[k*ADDR_W +: ADDR_W] = c_sel[k];
    for (int k = 1; k <= NUM_SRC; k++) mix_gain[(k-1)*GAIN_W +: GAIN_W] = c_gain[k];
    mix_enable = c_en; mix_length = ADDR_W'(c_len); mix_mode = c_mode;
    mix_start = 1; mix_abort = c_start_abort; s_cyc = cyc;
    @(negedge i_clk);
    mix_start = 0; mix_abort = 0;
    mix_select = {$urandom, $urandom, $urandom, $urandom};
    mix_length = ADDR_W'($urandom); mix_enable = NUM_SRC'($urandom);
    mix_gain = $urandom; mix_mode = 2'($urandom);
  endtask

  task automatic run_job(input string name);
    build_exp();
    act_q.delete(); done_cnt = 0; last_wdata = 32'hffffffff;
    drive_start();
    check({name, " busy"}, mix_busy, 1);
    for (int n = 0; n < 3000 && done_cnt == 0; n++) @(negedge i_clk);
    repeat (3) @(negedge i_clk);
    check({name, " done_pulses"}, done_cnt, 1);
    check({name, " busy_at_done"}, busy_at_done, 0);
    check({name, " busy_after"}, mix_busy, 0);
    check({name, " ev_count"}, act_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < act_q.size(); j++)
      check($sformatf("%s ev%0d", name, j), 64'(act_q[j]), 64'(exp_q[j]));
    if (c_len == 0) check({name, " latency"}, done_cyc - s_cyc, 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge i_clk);
    check("reset ctrl", {mix_busy, mix_done, mix_read, mix_write, play_audio_valid}, 0);
    check("reset data", {mix_addr, mix_writedata}, 0);
    i_rst = 0;

    // Two unity-gain sources
    default_cfg();
    c_sel[0] = 23'h100; c_sel[1] = 23'h1000; c_sel[2] = 23'h2000;
    c_en = 4'b0011;
    mem[23'h1000] = 32'h1000fff0; mem[23'h2000] = 32'h02340005;
    run_job("basic");
    check("basic wdata", last_wdata, 32'h1234fff5);

    // Saturation on both channels
    mem[23'h1000] = 32'h70009000; mem[23'h2000] = 32'h70009000;
    run_job("sat");
    check("sat wdata", last_wdata, 32'h7fff8000);

    // Half gain and zero gain on a single source
    c_en = 4'b0001; c_gain[1] = 8'd64; mem[23'h1000] = 32'h0100ff00;
    run_job("gain64");
    check("gain64 wdata", last_wdata, 32'h0080ff80);
    c_gain[1] = 8'd0;
    run_job("gain0");
    check("gain0 wdata", last_wdata, 32'h0);

    // Store and play with a stalled sink
    default_cfg(); c_mode = 2'b11; c_len = 3; c_stall = 5;
    run_job("mode11");

    // Zero length
    default_cfg(); c_mode = 2'b11; c_len = 0;
    run_job("len0");

    // Empty mask with mode 00
    default_cfg(); c_en = '0; c_mode = 2'b00; c_len = 2;
    run_job("nomask");
    check("nomask wdata", last_wdata, 32'h0);

    // Address wrap
    default_cfg(); c_en = 4'b0001; c_sel[1] = 23'h7fffff; c_len = 2;
    run_job("wrap");
    if (act_q.size() > 2) check("wrap addr", act_q[2].addr, 0);

    // Start and abort together: start wins
    default_cfg(); c_start_abort = 1; c_len = 2;
    run_job("start_abort");

    for (int r = 0; r < 10; r++) begin
      default_cfg();
      for (int k = 1; k <= NUM_SRC; k++) c_gain[k] = GAIN_W'($urandom);
      c_en = NUM_SRC'($urandom); c_len = $urandom_range(1, 4);
      c_mode = 2'($urandom); c_stall = $urandom_range(0, 3);
      run_job($sformatf("rand%0d", r));
    end

    // Abort during a read wait
    default_cfg(); c_en = 4'b0011; c_len = 2;
    act_q.delete(); done_cnt = 0; hold_fin = 1;
    drive_start();
    for (int n = 0; n < 50 && !mix_read; n++) @(negedge i_clk);
    check("abort read_seen", mix_read, 1);
    mix_abort = 1; @(negedge i_clk); mix_abort = 0;
    repeat (3) @(negedge i_clk);
    check("abort read_held", mix_read, 1);
    hold_fin = 0;
    for (int n = 0; n < 20 && act_q.size() == 0; n++) @(negedge i_clk);
    if (cyc == fin_cyc) @(negedge i_clk);
    check("abort idle_busy", mix_busy, 0);
    check("abort idle_req", {mix_read, mix_write}, 0);
    repeat (4) @(negedge i_clk);
    check("abort ev_count", act_q.size(), 1);
    check("abort no_done", done_cnt, 0);
    default_cfg(); c_len = 2;
    run_job("after_abort");

    // Reset while playing
    default_cfg(); c_mode = 2'b10; c_stall = 1000;
    drive_start();
    for (int n = 0; n < 100 && !play_audio_valid; n++) @(negedge i_clk);
    check("rstplay valid_seen", play_audio_valid, 1);
    #2 i_rst = 1;
    #1;
    check("rstplay ctrl", {mix_busy, mix_done, mix_read, mix_write, play_audio_valid}, 0);
    check("rstplay data", {mix_addr, mix_writedata}, 0);
    check("rstplay pdata", play_audio_data, 0);
    @(negedge i_clk); i_rst = 0;
    default_cfg(); c_mode = 2'b11; c_len = 2; c_stall = 1;
    run_job("after_reset");

    check("protocol", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mix_core_n.md
Name: mix_core_n

Overview:
- Parametrised successor mixer. Reads NUM_SRC source tracks from SDRAM word by word and applies a per-source gain to each.
- Sums the tracks with saturation per stereo channel. Depending on mode, it writes the mix back to a storage region in SDRAM, streams it to the audio output, or both.
- Sits between the top controller, the SDRAM arbiter port and the audio playback interface.

Parameters:
- NUM_SRC, 4: number of source tracks (1..8).
- ADDR_W, 23: SDRAM word address width.
- GAIN_W, 8: unsigned gain width. A gain of 2^(GAIN_W-1) is unity.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- mix_start  in  1  single-cycle start pulse; ignored unless idle
- mix_abort  in  1  request to stop the current job
- mix_select  in  (NUM_SRC+1)*ADDR_W  base addresses. Slice 0 is the storage destination; slice k (1..NUM_SRC) is source k.
- mix_length  in  ADDR_W  number of 32-bit words to mix
- mix_enable  in  NUM_SRC  per-source enable mask; bit k-1 enables source k
- mix_gain  in  NUM_SRC*GAIN_W  per-source gain; slice k-1 belongs to source k
- mix_mode  in  2  01 = store only, 10 = play only, 11 = store and play, 00 = treated as 01
- mix_busy  out  1  high from the cycle after an accepted start until done or abort
- mix_done  out  1  one-cycle pulse at normal completion
- mix_read  out  1  SDRAM read request
- mix_write  out  1  SDRAM write request
- mix_addr  out  ADDR_W  SDRAM address
- mix_writedata  out  32  SDRAM write data
- mix_readdata  in  32  SDRAM read data; valid when mix_sdram_finished is high
- mix_sdram_finished  in  1  SDRAM completion strobe
- play_audio_valid  out  1  audio output valid
- play_audio_data  out  32  audio output sample
- play_audio_ready  in  1  audio sink ready

Behaviour:
- Reset (async, i_rst=1): FSM in IDLE. All outputs are 0. Word index, accumulators and latched configuration are cleared.
- Data format: 32-bit word = {L[31:16], R[15:0]}, each channel 16-bit two's complement.
- Start: in IDLE, mix_start=1 latches mix_select, mix_length, mix_enable, mix_gain and mix_mode; index i=0. Inputs changing after start have no effect.
- FSM states: IDLE -> CLR -> READ -> WRITE -> PLAY -> NEXT -> DONE.
- CLR: zero both channel accumulators. Go to READ on the lowest enabled source, or straight to SAT/output if the mask is 0. In that case the mixed word is 0.
- READ:
  - mix_read=1, mix_addr = select[k] + i, modulo 2^ADDR_W (wraps silently).
  - Request held stable until mix_sdram_finished=1; mix_read drops the following cycle.
  - On finished, each channel: acc += (sample * gain_k) >>> (GAIN_W-1), arithmetic shift, signed.
  - Accumulator width is 16+GAIN_W+clog2(NUM_SRC)+1, so it cannot overflow internally.
  - Then advance to the next enabled source in ascending k; after the last one go to SAT.
- SAT (1 cycle): each channel clamps to [-32768, 32767], then the mixed word is registered.
- WRITE (if mode bit0): mix_write=1, mix_addr = select[0] + i, mix_writedata = mixed word. Held until finished.
- PLAY (if mode bit1): play_audio_valid=1 with data = mixed word. Data is stable while valid and not ready. Transfer occurs on valid&&ready; valid drops the next cycle.
- When both mode bits are set, WRITE completes before PLAY.
- NEXT: i++. If i == length go to DONE, else CLR.
- DONE: mix_done=1 for exactly one cycle, mix_busy=0 that cycle, then IDLE.
- mix_length=0: no SDRAM or audio traffic; mix_done pulses 2 cycles after the start pulse.
- mix_read and mix_write are never high together. At most one SDRAM request is outstanding.
- mix_sdram_finished outside READ/WRITE is ignored.
- Abort:
  - Sampled in any non-IDLE state and held pending internally.
  - In READ or WRITE, the in-flight request completes (finished) first.
  - In PLAY, the current handshake completes first.
  - Otherwise abort takes effect immediately: the FSM goes to IDLE the next cycle, no mix_done, mix_busy=0.
- mix_start while busy is ignored. mix_start and mix_abort together in IDLE: start wins and the abort is discarded.
- Async reset mid-job returns to IDLE immediately and drops all request lines.

Test Plan:
- NUM_SRC=4. Sources 1,2 enabled, gains 128 (unity), length 1, mode 01. Src1={0x1000,0xFFF0}, src2={0x0234,0x0005} -> exactly 2 reads then 1 write to select[0]; writedata=0x1234FFF5; mix_done one pulse.
- Saturation: both sources {0x7000,0x9000}, unity gains -> mixed word {0x7FFF,0x8000}.
- Gain: one source, gain 64, sample {0x0100,0xFF00} -> {0x0080,0xFF80}. Gain 0 -> 0x00000000.
- Mode 11, length 3, play_audio_ready held low 5 cycles per word -> for each i, the write precedes valid; data is stable while stalled; 3 audio transfers; done after the third.
- Edge cases:
  - mix_length=0 -> done exactly 2 cycles after start, no mix_read/mix_write.
  - mix_enable=0, mode 01 -> writes 0x00000000 with no reads.
  - Base 0x7FFFFF with i=1 -> address 0x000000.
- Abort raised during a read wait -> read completes on finished; no write, no done; IDLE next cycle. A new start is then accepted. Reset asserted mid-PLAY -> all outputs 0 immediately.
